// File: rtl/mmio_pkg.sv
// Shared definitions for the CPU data-bus MMIO window: base addresses,
// responder state encoding and fixed register indices.
package mmio_pkg;

  localparam int unsigned SLAVE_BASE  = 10000;
  localparam int unsigned MASTER_BASE = 11000;

  localparam int unsigned REG_CTRL   = 0;
  localparam int unsigned REG_STATUS = 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } slave_state_t;

endpackage

// File: rtl/slave_regfile.sv
// NREGS x 32 register bank with per-byte write enables and a combinational
// read port; index REG_STATUS never accepts writes.
module slave_regfile
  import mmio_pkg::*;
#(
  parameter int NREGS = 16,
  localparam int IW = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_idx,
  input  logic [3:0]    wr_be,
  input  logic [31:0]   wr_data,
  input  logic [IW-1:0] rd_idx,
  output logic [31:0]   rd_data,
  output logic [31:0]   reg0
);

  logic [31:0]      regs [NREGS];
  logic [NREGS-1:0] wr_hit;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_hit
      // the status slot is wired off here, so it stays at its reset value
      if (gi == int'(REG_STATUS)) begin : g_ro
        assign wr_hit[gi] = 1'b0;
      end else begin : g_rw
        assign wr_hit[gi] = wr_en && (wr_idx == IW'(gi));
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NREGS; i++)
        for (int b = 0; b < 4; b++)
          if (wr_hit[i] && wr_be[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
    end
  end

  assign rd_data = regs[rd_idx];
  assign reg0    = regs[int'(REG_CTRL)];

endmodule

// File: rtl/mmio_slave_responder.sv
// Slave-side MMIO responder: captures a CPU request, waits WAIT_CYCLES, commits
// and pulses done_slave. Define MMIO_SLAVE_ERR_EN to add the err_slave output.
module mmio_slave_responder #(
  parameter int SLAVE_BASE  = mmio_pkg::SLAVE_BASE,
  parameter int NREGS       = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_slave,
  input  logic [31:0] daddr,
  input  logic [3:0]  we,
  input  logic [31:0] dwdata,
  output logic [31:0] drdata,
  output logic        done_slave,
  output logic [31:0] ctrl_o,
`ifdef MMIO_SLAVE_ERR_EN
  output logic        err_slave,
`endif
  input  logic [31:0] status_i
);
  import mmio_pkg::*;

  localparam int IW        = $clog2(NREGS);
  localparam bit ZERO_WAIT = (WAIT_CYCLES == 0);

  slave_state_t  state_reg;
  logic [3:0]    cnt_reg;
  logic [IW-1:0] idx_reg;
  logic [3:0]    we_reg;
  logic [31:0]   data_reg;
  logic          in_range_reg;

  logic [31:0]   offset_live;
  logic          in_range_live;
  logic [IW-1:0] idx_live;
  logic [IW-1:0] req_idx;
  logic [3:0]    req_we;
  logic [31:0]   req_data;
  logic          req_in_range;
  logic          commit;
  logic          wr_en;
  logic [31:0]   rd_data;

  assign offset_live   = daddr - 32'(SLAVE_BASE);
  assign in_range_live = (daddr >= 32'(SLAVE_BASE)) && (offset_live < 32'(NREGS * 4));
  assign idx_live      = offset_live[IW+1:2];

  // A zero-wait build commits straight from IDLE, so it must see the live request.
  always_comb begin
    req_idx      = idx_reg;
    req_we       = we_reg;
    req_data     = data_reg;
    req_in_range = in_range_reg;
    if (state_reg == IDLE) begin
      req_idx      = idx_live;
      req_we       = we;
      req_data     = dwdata;
      req_in_range = in_range_live;
    end
  end

  assign commit = en_slave &&
                  ((state_reg == IDLE && ZERO_WAIT) || (state_reg == WAIT && cnt_reg == 4'd0));
  assign wr_en  = commit && req_in_range && (req_we != 4'd0);

  slave_regfile #(.NREGS(NREGS)) u_regfile (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_idx  (req_idx),
    .wr_be   (req_we),
    .wr_data (req_data),
    .rd_idx  (req_idx),
    .rd_data (rd_data),
    .reg0    (ctrl_o)
  );

`ifdef MMIO_SLAVE_ERR_EN
  logic mis_reg;
  logic req_mis;
  logic err_next;

  assign req_mis  = (state_reg == IDLE) ? (daddr[1:0] != 2'b00) : mis_reg;
  assign err_next = !req_in_range || req_mis ||
                    ((req_we != 4'd0) && (req_idx == IW'(REG_STATUS)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mis_reg   <= 1'b0;
      err_slave <= 1'b0;
    end else begin
      if (state_reg == IDLE && en_slave) mis_reg <= (daddr[1:0] != 2'b00);
      err_slave <= commit && err_next;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      cnt_reg      <= 4'd0;
      idx_reg      <= '0;
      we_reg       <= 4'd0;
      data_reg     <= 32'd0;
      in_range_reg <= 1'b0;
      done_slave   <= 1'b0;
      drdata       <= 32'd0;
    end else begin
      done_slave <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (en_slave) begin
            idx_reg      <= idx_live;
            we_reg       <= we;
            data_reg     <= dwdata;
            in_range_reg <= in_range_live;
            cnt_reg      <= 4'(WAIT_CYCLES - 1);
            state_reg    <= ZERO_WAIT ? DONE : WAIT;
          end
        end
        WAIT: begin
          // a stalled CPU that drops its strobe has abandoned the access
          if (!en_slave)             state_reg <= IDLE;
          else if (cnt_reg == 4'd0)  state_reg <= DONE;
          else                       cnt_reg   <= cnt_reg - 4'd1;
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase

      if (commit) begin
        done_slave <= 1'b1;
        if (req_we == 4'd0) begin
          if (!req_in_range)                    drdata <= 32'd0;
          else if (req_idx == IW'(REG_STATUS))  drdata <= status_i;
          else                                  drdata <= rd_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_mmio_slave_responder.sv
// Directed and randomized checks of mmio_slave_responder against an
// array-based model of the register window.
`timescale 1ns/1ps
module tb_mmio_slave_responder;

  localparam int BASE  = 10000;
  localparam int NR    = 16;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en_slave = 1'b0;
  logic [31:0] daddr = '0;
  logic [3:0]  we = '0;
  logic [31:0] dwdata = '0;
  logic [31:0] drdata;
  logic        done_slave;
  logic [31:0] ctrl_o;
  logic [31:0] status_i = '0;
`ifdef MMIO_SLAVE_ERR_EN
  logic        err_slave;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [NR];
  logic [31:0] m_rd;
  logic        m_err;

  mmio_slave_responder #(
    .SLAVE_BASE(BASE), .NREGS(NR), .WAIT_CYCLES(WAITC)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_slave(en_slave), .daddr(daddr), .we(we),
    .dwdata(dwdata), .drdata(drdata), .done_slave(done_slave), .ctrl_o(ctrl_o),
`ifdef MMIO_SLAVE_ERR_EN
    .err_slave(err_slave),
`endif
    .status_i(status_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_rd  = '0;
    m_err = 1'b0;
  endtask

  // Reference behaviour of one completed access.
  task automatic model_access(input logic [31:0] a, input logic [3:0] w, input logic [31:0] d);
    bit ok;
    int idx;
    ok  = (a >= 32'(BASE)) && ((a - 32'(BASE)) < 32'(NR * 4));
    idx = ok ? int'((a - 32'(BASE)) / 4) : 0;
    m_err = !ok || (a % 4 != 0) || (w != 0 && idx == 1);
    if (w == 0) begin
      m_rd = !ok ? 32'd0 : (idx == 1 ? status_i : m_regs[idx]);
    end else if (ok && idx != 1) begin
      for (int b = 0; b < 4; b++)
        if (w[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
    end
  endtask

  task automatic access(input string tag, input logic [31:0] a, input logic [3:0] w,
                        input logic [31:0] d);
    int k;
    k = 0;
    model_access(a, w, d);
    @(negedge clk);
    daddr = a; we = w; dwdata = d; en_slave = 1'b1;
    for (int c = 1; c <= 20 && k == 0; c++) begin
      @(posedge clk); #1;
      if (done_slave) begin
        k = c;
        en_slave = 1'b0;
      end
    end
    en_slave = 1'b0;
    $display("access %s addr=%0d we=%b data=%h done_at=%0d drdata=%h ctrl=%h",
             tag, a, w, d, k, drdata, ctrl_o);
    check({tag, ".latency"}, 32'(k), 32'(WAITC + 1));
    if (k != 0) begin
      check({tag, ".ctrl"}, ctrl_o, m_regs[0]);
      check({tag, ".drdata"}, drdata, m_rd);
`ifdef MMIO_SLAVE_ERR_EN
      check({tag, ".err"}, 32'(err_slave), 32'(m_err));
`endif
      @(posedge clk); #1;
      check({tag, ".done_width"}, 32'(done_slave), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    logic [31:0] mask;
    bit          seen;

    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset.done", 32'(done_slave), 32'd0);
    check("reset.drdata", drdata, 32'd0);
    check("reset.ctrl", ctrl_o, 32'd0);
`ifdef MMIO_SLAVE_ERR_EN
    check("reset.err", 32'(err_slave), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    access("wr8", 32'd10008, 4'b1111, 32'hA5A5_1234);
    access("rd8", 32'd10008, 4'b0000, 32'h0);
    access("wr0_full", 32'd10000, 4'b1111, 32'h1111_1111);
    access("wr0_low", 32'd10000, 4'b0011, 32'hFFFF_BEEF);
    check("ctrl_merge", ctrl_o, 32'h1111_BEEF);

    status_i = 32'h0000_00C3;
    access("rd_status", 32'd10004, 4'b0000, 32'h0);
    access("wr_status", 32'd10004, 4'b1111, 32'hDEAD_BEEF);
    access("rd_status2", 32'd10004, 4'b0000, 32'h0);

    access("rd_oor", 32'd10064, 4'b0000, 32'h0);
    access("wr_oor", 32'd10064, 4'b1111, 32'hFFFF_FFFF);
    access("wr_low", 32'd9996, 4'b1111, 32'hFFFF_FFFF);
    access("rd_mis", 32'd10010, 4'b0000, 32'h0);
    for (int i = 0; i < NR; i++)
      access($sformatf("scan%0d", i), 32'(BASE + 4 * i), 4'b0000, 32'h0);

    // Two requests with the strobe held high throughout.
    mask = '0;
    model_access(32'd10012, 4'b1111, 32'h0BAD_F00D);
    model_access(32'd10012, 4'b0000, 32'h0);
    @(negedge clk);
    daddr = 32'd10012; we = 4'b1111; dwdata = 32'h0BAD_F00D; en_slave = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      if (done_slave) begin
        mask[c] = 1'b1;
        we = 4'b0000;
      end
    end
    en_slave = 1'b0;
    $display("back_to_back done_mask=%h drdata=%h", mask, drdata);
    check("b2b.done_cycles", mask, 32'h0000_0088);
    check("b2b.drdata", drdata, m_rd);

    // Abort a write by dropping the strobe during the wait.
    seen = 1'b0;
    @(negedge clk);
    daddr = 32'd10008; we = 4'b1111; dwdata = 32'h0000_DEAD; en_slave = 1'b1;
    @(posedge clk); #1;
    en_slave = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (done_slave) seen = 1'b1;
    end
    $display("abort done_seen=%0d", seen);
    check("abort.no_done", 32'(seen), 32'd0);
    access("abort_rd", 32'd10008, 4'b0000, 32'h0);

    // Reset while a write is waiting.
    seen = 1'b0;
    @(negedge clk);
    daddr = 32'd10000; we = 4'b1111; dwdata = 32'h1234_5678; en_slave = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_mid.ctrl", ctrl_o, 32'd0);
    check("rst_mid.drdata", drdata, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (done_slave) seen = 1'b1;
    end
    $display("reset_mid done_seen=%0d ctrl=%h", seen, ctrl_o);
    check("rst_mid.no_done", 32'(seen), 32'd0);
    check("rst_mid.ctrl_hold", ctrl_o, 32'd0);
    @(negedge clk);
    en_slave = 1'b0;
    rst_n = 1'b1;
    access("post_rst_rd8", 32'd10008, 4'b0000, 32'h0);

    // Randomized traffic across, below and above the window.
    for (int n = 0; n < 60; n++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 7)       a = 32'(BASE + $urandom_range(0, NR * 4 - 1));
      else if (r == 7) a = 32'(BASE + NR * 4 + $urandom_range(0, 200));
      else             a = 32'(BASE - $urandom_range(1, 50));
      w = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      status_i = $urandom;
      access($sformatf("rnd%0d", n), a, w, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
